// File: rtl/issue_hazard_gate.sv
// One-entry ID-stage issue buffer: holds a decoded instruction until its sources clear in the
// register-invalid scoreboard, then issues it to EX. Optional build macro: ISSUE_FWD_EN.
module issue_hazard_gate #(
   parameter int PAYLOAD_W  = 16,
   parameter int STALLCNT_W = 16,
   parameter int FWD_THRESH = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_rs_adr,
   input  logic [2:0]            in_rt_adr,
   input  logic                  in_rs_use,
   input  logic                  in_rt_use,
   input  logic [2:0]            in_rd_adr,
   input  logic                  in_regwrite,
   input  logic                  in_from_mem,
   input  logic [PAYLOAD_W-1:0]  in_payload,
   input  logic                  flush,
   input  logic [2:0]            register_invalid [7:0],
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PAYLOAD_W-1:0]  out_payload,
   output logic                  regwrite_cur,
   output logic                  from_main_mem_id,
   output logic [2:0]            regwrite_adr_id,
   output logic                  stalled,
   output logic [STALLCNT_W-1:0] stall_cycles
);

   typedef enum logic {EMPTY, HELD} state_t;

   typedef struct packed {
      logic [2:0]           rs;
      logic [2:0]           rt;
      logic                 rs_use;
      logic                 rt_use;
      logic [2:0]           rd;
      logic                 regwrite;
      logic                 from_mem;
      logic [PAYLOAD_W-1:0] payload;
   } instr_t;

   // Largest pending count that still counts as ready (EX forwards those results).
`ifdef ISSUE_FWD_EN
   localparam logic [2:0] READY_MAX = 3'(FWD_THRESH);
`else
   localparam logic [2:0] READY_MAX = 3'd0;
`endif

   state_t state, state_nxt;
   instr_t held, in_instr;
   logic   src_a_busy, src_b_busy, hazard, fire, accept;

   assign in_instr = '{rs: in_rs_adr, rt: in_rt_adr, rs_use: in_rs_use, rt_use: in_rt_use,
                       rd: in_rd_adr, regwrite: in_regwrite, from_mem: in_from_mem,
                       payload: in_payload};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      src_a_busy = held.rs_use && (register_invalid[held.rs] > READY_MAX);
      src_b_busy = held.rt_use && (register_invalid[held.rt] > READY_MAX);
      hazard     = src_a_busy || src_b_busy;
      out_valid  = (state == HELD) && !hazard && !flush;
      fire       = out_valid && out_ready;
      // in_ready depends only on state, scoreboard, flush and out_ready, never on in_valid
      in_ready   = ((state == EMPTY) || fire) && !flush;
      accept     = in_valid && in_ready;
      stalled    = (state == HELD) && hazard;
      case (state)
         EMPTY: if (accept) state_nxt = HELD;
         HELD: begin
            if (flush)                state_nxt = EMPTY;
            else if (fire && !accept) state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              held <= '0;
      else if (accept)        held <= in_instr;
      else if (fire || flush) held <= '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 stall_cycles <= '0;
      else if (stalled && (stall_cycles != '1))  stall_cycles <= stall_cycles + 1'b1;
   end

   assign out_payload      = held.payload;
   assign regwrite_cur     = fire && held.regwrite;
   assign from_main_mem_id = held.from_mem;
   assign regwrite_adr_id  = held.rd;

endmodule

// File: tb/tb_issue_hazard_gate.sv
// Directed self-checking bench for issue_hazard_gate; STALLCNT_W is narrowed so saturation is reachable.
module tb_issue_hazard_gate;
   localparam int PW = 16;
   localparam int SW = 4;

   logic          clk = 0;
   logic          reset;
   logic          in_valid, in_ready;
   logic [2:0]    in_rs_adr, in_rt_adr, in_rd_adr;
   logic          in_rs_use, in_rt_use, in_regwrite, in_from_mem;
   logic [PW-1:0] in_payload;
   logic          flush;
   logic [2:0]    ri [7:0];
   logic          out_valid, out_ready;
   logic [PW-1:0] out_payload;
   logic          regwrite_cur, from_main_mem_id;
   logic [2:0]    regwrite_adr_id;
   logic          stalled;
   logic [SW-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;
   int exp_stall = 0;

   issue_hazard_gate #(.PAYLOAD_W(PW), .STALLCNT_W(SW), .FWD_THRESH(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs_adr(in_rs_adr), .in_rt_adr(in_rt_adr), .in_rs_use(in_rs_use), .in_rt_use(in_rt_use),
      .in_rd_adr(in_rd_adr), .in_regwrite(in_regwrite), .in_from_mem(in_from_mem),
      .in_payload(in_payload), .flush(flush), .register_invalid(ri),
      .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
      .regwrite_cur(regwrite_cur), .from_main_mem_id(from_main_mem_id),
      .regwrite_adr_id(regwrite_adr_id), .stalled(stalled), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] rs, input logic rsu, input logic [2:0] rt, input logic rtu,
                        input logic [2:0] rd, input logic rw, input logic fm, input logic [PW-1:0] pl);
      in_valid = 1; in_rs_adr = rs; in_rs_use = rsu; in_rt_adr = rt; in_rt_use = rtu;
      in_rd_adr = rd; in_regwrite = rw; in_from_mem = fm; in_payload = pl;
   endtask

   task automatic test_reset();
      reset = 1; in_valid = 0; flush = 0; out_ready = 0;
      in_rs_adr = 0; in_rt_adr = 0; in_rs_use = 0; in_rt_use = 0; in_rd_adr = 0;
      in_regwrite = 0; in_from_mem = 0; in_payload = 0;
      for (int i = 0; i < 8; i++) ri[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
      checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
      reset = 0;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
      // hold a stalled instruction, then unblock it with EX not ready, then reset mid-cycle
      ri[1] = 3;
      drive(3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 16'h1111);
      step();
      in_valid = 0;
      checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL rst_hold_stalled got %0b exp 1", stalled); end
      step();
      checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL rst_hold_cnt got %0d exp 1", stall_cycles); end
      ri[1] = 0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_valid got %0b exp 1", out_valid); end
      reset = 1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0b exp 0", out_valid); end
      step();
      reset = 0;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_after_in_ready got %0b exp 1", in_ready); end
      checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL rst_after_cnt got %0d exp 0", stall_cycles); end
      exp_stall = 0;
   endtask

   task automatic test_no_hazard();
      out_ready = 1;
      drive(3'd2, 1, 3'd3, 1, 3'd5, 1, 1, 16'hA5A5);
      step();
      in_valid = 0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nohaz_valid got %0b exp 1", out_valid); end
      checks++; if (regwrite_cur !== 1'b1) begin errors++; $display("FAIL nohaz_regwrite got %0b exp 1", regwrite_cur); end
      checks++; if (regwrite_adr_id !== 3'd5) begin errors++; $display("FAIL nohaz_rd got %0d exp 5", regwrite_adr_id); end
      checks++; if (from_main_mem_id !== 1'b1) begin errors++; $display("FAIL nohaz_from_mem got %0b exp 1", from_main_mem_id); end
      checks++; if (out_payload !== 16'hA5A5) begin errors++; $display("FAIL nohaz_payload got %h exp a5a5", out_payload); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nohaz_empty_valid got %0b exp 0", out_valid); end
      checks++; if (regwrite_adr_id !== 3'd0) begin errors++; $display("FAIL nohaz_empty_rd got %0d exp 0", regwrite_adr_id); end
   endtask

   task automatic test_hazard();
      out_ready = 1;
      ri[4] = 2;
      drive(3'd4, 1, 3'd0, 0, 3'd1, 1, 0, 16'h4444);
      step();
      in_valid = 0;
      checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL haz_c1_stalled got %0b exp 1", stalled); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL haz_c1_valid got %0b exp 0", out_valid); end
      step();
      exp_stall++;
      ri[4] = 1;
      #1;
`ifdef ISSUE_FWD_EN
      checks++; if (out_valid !== 1'b1 || regwrite_cur !== 1'b1) begin errors++; $display("FAIL haz_c2_fwd_fire got v=%0b rw=%0b exp 1 1", out_valid, regwrite_cur); end
      step();
      ri[4] = 0;
`else
      checks++; if (stalled !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL haz_c2_stall got st=%0b v=%0b exp 1 0", stalled, out_valid); end
      step();
      exp_stall++;
      ri[4] = 0;
      #1;
      checks++; if (out_valid !== 1'b1 || regwrite_cur !== 1'b1 || stalled !== 1'b0) begin errors++; $display("FAIL haz_c3_fire got v=%0b rw=%0b st=%0b exp 1 1 0", out_valid, regwrite_cur, stalled); end
      step();
`endif
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL haz_done_valid got %0b exp 0", out_valid); end
      checks++; if (stall_cycles !== SW'(exp_stall)) begin errors++; $display("FAIL haz_stall_cycles got %0d exp %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_unused_source();
      out_ready = 1;
      ri[6] = 3;
      drive(3'd0, 0, 3'd6, 0, 3'd7, 0, 0, 16'h0606);
      step();
      in_valid = 0;
      checks++; if (stalled !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL unused_fire got st=%0b v=%0b exp 0 1", stalled, out_valid); end
      checks++; if (regwrite_cur !== 1'b0) begin errors++; $display("FAIL unused_regwrite got %0b exp 0", regwrite_cur); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unused_empty got %0b exp 0", out_valid); end
      checks++; if (stall_cycles !== SW'(exp_stall)) begin errors++; $display("FAIL unused_cnt got %0d exp %0d", stall_cycles, exp_stall); end
      ri[6] = 0;
   endtask

   task automatic test_back_to_back();
      out_ready = 1;
      drive(3'd1, 1, 3'd2, 1, 3'd3, 1, 0, 16'hB001);
      step();
      drive(3'd1, 1, 3'd2, 1, 3'd4, 1, 0, 16'hB002);
      #1;
      checks++; if (in_ready !== 1'b1 || out_payload !== 16'hB001) begin errors++; $display("FAIL b2b_a got rdy=%0b pl=%h exp 1 b001", in_ready, out_payload); end
      step();
      drive(3'd1, 1, 3'd2, 1, 3'd5, 1, 0, 16'hB003);
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_payload !== 16'hB002) begin errors++; $display("FAIL b2b_b got rdy=%0b v=%0b pl=%h exp 1 1 b002", in_ready, out_valid, out_payload); end
      step();
      out_ready = 0;
      drive(3'd1, 1, 3'd2, 1, 3'd6, 1, 0, 16'hB004);
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_payload !== 16'hB003) begin errors++; $display("FAIL b2b_bp1 got rdy=%0b v=%0b pl=%h exp 0 1 b003", in_ready, out_valid, out_payload); end
      step();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_payload !== 16'hB003) begin errors++; $display("FAIL b2b_bp2 got rdy=%0b v=%0b pl=%h exp 0 1 b003", in_ready, out_valid, out_payload); end
      step();
      in_valid = 0;
      out_ready = 1;
      #1;
      checks++; if (regwrite_cur !== 1'b1 || out_payload !== 16'hB003 || regwrite_adr_id !== 3'd5) begin errors++; $display("FAIL b2b_release got rw=%0b pl=%h rd=%0d exp 1 b003 5", regwrite_cur, out_payload, regwrite_adr_id); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_d got %0b exp 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1;
      ri[2] = 3;
      drive(3'd2, 1, 3'd0, 0, 3'd3, 1, 1, 16'hF00F);
      step();
      checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL flush_pre_stalled got %0b exp 1", stalled); end
      step();
      exp_stall++;
      flush = 1;
      drive(3'd0, 0, 3'd0, 0, 3'd7, 1, 0, 16'hDEAD);
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || regwrite_cur !== 1'b0) begin errors++; $display("FAIL flush_cycle got rdy=%0b v=%0b rw=%0b exp 0 0 0", in_ready, out_valid, regwrite_cur); end
      step();
      exp_stall++;
      flush = 0;
      in_valid = 0;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || stalled !== 1'b0 || regwrite_adr_id !== 3'd0) begin errors++; $display("FAIL flush_after got rdy=%0b v=%0b st=%0b rd=%0d exp 1 0 0 0", in_ready, out_valid, stalled, regwrite_adr_id); end
      checks++; if (stall_cycles !== SW'(exp_stall)) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_saturation();
      out_ready = 1;
      ri[3] = 3;
      drive(3'd0, 0, 3'd3, 1, 3'd1, 0, 0, 16'h5A7A);
      step();
      in_valid = 0;
      repeat (20) step();
      checks++; if (stall_cycles !== 4'hF) begin errors++; $display("FAIL sat_cnt got %0d exp 15", stall_cycles); end
      checks++; if (out_payload !== 16'h5A7A || stalled !== 1'b1) begin errors++; $display("FAIL sat_hold got pl=%h st=%0b exp 5a7a 1", out_payload, stalled); end
      flush = 1;
      step();
      flush = 0;
      ri[3] = 0;
      #1;
      checks++; if (stall_cycles !== 4'hF || in_ready !== 1'b1) begin errors++; $display("FAIL sat_after got cnt=%0d rdy=%0b exp 15 1", stall_cycles, in_ready); end
   endtask

   initial begin
      test_reset();
      test_no_hazard();
      test_hazard();
      test_unused_source();
      test_back_to_back();
      test_flush();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/issue_hazard_gate.md
Name: issue_hazard_gate

Overview:
- One-entry ID-stage issue buffer. It sits directly upstream of the register-invalid scoreboard and also consumes that scoreboard's output.
- It captures a decoded instruction from fetch/decode and holds it while any source register is still pending in register_invalid.
- Once sources clear, it issues the instruction to EX with a valid/ready handshake.
- On issue, it drives regwrite_cur / from_main_mem_id / regwrite_adr_id, which mark the destination register invalid in the scoreboard.

Parameters:
- PAYLOAD_W, 16, width of opaque instruction payload passed through to EX
- STALLCNT_W, 16, width of saturating stall performance counter
- FWD_THRESH, 1, highest register_invalid value treated as ready when forwarding is enabled

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  decode has an instruction
- in_ready  output  1  buffer accepts this cycle
- in_rs_adr  input  3  source register A
- in_rt_adr  input  3  source register B
- in_rs_use  input  1  source A is read
- in_rt_use  input  1  source B is read
- in_rd_adr  input  3  destination register
- in_regwrite  input  1  instruction writes rd
- in_from_mem  input  1  rd result comes from main memory (load)
- in_payload  input  PAYLOAD_W  opaque fields
- flush  input  1  discard held instruction (branch redirect)
- register_invalid  input  3 x [7:0] (unpacked array)  per-register pending count from scoreboard
- out_valid  output  1  instruction available to EX
- out_ready  input  1  EX accepts
- out_payload  output  PAYLOAD_W  held payload
- regwrite_cur  output  1  issue fire and held regwrite
- from_main_mem_id  output  1  held from_mem
- regwrite_adr_id  output  3  held rd
- stalled  output  1  held instruction blocked by hazard this cycle
- stall_cycles  output  STALLCNT_W  saturating count of stalled cycles

Behaviour:
- Reset and synchronous clock:
  - Clock is clk; reset is asynchronous and active-high. Reset may assert at any time; it clears state immediately and drops out_valid the same cycle.
  - Reset values: state EMPTY, all held fields 0, stall_cycles 0. Therefore out_valid=0, regwrite_cur=0, stalled=0, and in_ready=1 one cycle after reset deasserts.
- FSM states:
  - EMPTY, HELD.
  - EMPTY -> HELD on accept (in_valid && in_ready && !flush).
  - HELD -> EMPTY on fire, unless a new accept occurs in the same cycle (then it stays HELD with new contents).
  - HELD -> EMPTY on flush.
- Hazard (combinational, from registered fields and the current register_invalid):
  - srcA_busy = held_rs_use && register_invalid[held_rs] != 0
  - srcB_busy = held_rt_use && register_invalid[held_rt] != 0
  - hazard = srcA_busy || srcB_busy
  - Unused sources are never checked.
- Outputs:
  - out_valid = HELD && !hazard && !flush
  - fire = out_valid && out_ready
  - in_ready = EMPTY || fire; no combinational path from in_valid
  - regwrite_cur = fire && held_regwrite
  - from_main_mem_id and regwrite_adr_id always reflect the held fields (0 when EMPTY)
  - stalled = HELD && hazard
- Latency:
  - An accepted instruction can fire no earlier than the next cycle.
  - A back-to-back dependent instruction accepted on its predecessor's fire cycle is evaluated the following cycle, when the scoreboard already shows rd pending. No same-cycle bypass compare is needed.
- Flush:
  - Clears HELD with no fire and no regwrite_cur.
  - in_ready=0 during flush; an in_valid presented in that cycle is not accepted.
- EX backpressure:
  - While out_ready=0 and no hazard, the instruction stays held with fields stable.
  - out_valid, once high, stays high until fire, flush or reset. Exception: the scoreboard may re-raise hazard only if an external writer marks a source register pending.
- stall_cycles:
  - Increments every cycle stalled=1.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Register 0 receives no special treatment.

Optional Feature:
- Macro: ISSUE_FWD_EN.
- Defined: a source counts as busy only if register_invalid[r] > FWD_THRESH. Values 1..FWD_THRESH are treated as ready, because EX forwards them.
- Undefined: any nonzero count is busy, per the Hazard rule above.
- Port list is identical in both builds.

Test Plan:
- Reset mid-hold:
  - Stimulus: accept an instruction, then assert reset while HELD with out_ready=0.
  - Response: out_valid=0 immediately; after release, in_ready=1 and stall_cycles=0.
- No hazard:
  - Stimulus: register_invalid all 0; accept rs=2, rt=3, rd=5, regwrite=1, from_mem=1; out_ready=1.
  - Response: next cycle fire, regwrite_cur=1, regwrite_adr_id=5, from_main_mem_id=1.
- Hazard:
  - Stimulus: register_invalid[4]=2, held rs=4, rs_use=1; count decrements 2->1->0 over cycles.
  - Response: stalled=1 for 2 cycles, stall_cycles=2, fire on the cycle register_invalid[4]=0.
  - With ISSUE_FWD_EN and FWD_THRESH=1: stalled for 1 cycle only.
- Unused source:
  - Stimulus: register_invalid[6]=3, held rt=6, rt_use=0.
  - Response: no stall, immediate fire.
- Back-to-back and backpressure:
  - Stimulus: a stream of 3 independent instructions with out_ready=1.
  - Response: one fire per cycle and in_ready held high.
  - Stimulus: then drop out_ready for 2 cycles.
  - Response: payload stable, in_ready=0.
- Flush:
  - Stimulus: flush while HELD and stalled, with in_valid=1 in the same cycle.
  - Response: no fire, regwrite_cur=0, nothing captured; next cycle EMPTY and in_ready=1.
